// File: rtl/timepulse_gen_if.sv
// Timepulse generator bus: control/request inputs and timing outputs.
//   CLOCK_EN       phase-advance enable
//   GOJ1/STRT1/STRT2/SBY  restart requests (level-sensitive)
//   MSTP/MSTRTP    monitor stop / monitor start
//   WL15/WL16      write-line sign bits sampled into OVF/UNF
//   T, PHS         one-hot timepulse and phase
//   MCT_END, GOJAM, STOPPED, FS, OVF, UNF  status outputs
// master drives the requests, slave (the generator) drives the timing outputs.
interface timepulse_gen_if #(
    parameter int unsigned NUM_TP   = 12,
    parameter int unsigned PHASES   = 4,
    parameter int unsigned SCALER_W = 8
);
    logic                CLOCK_EN;
    logic                GOJ1;
    logic                STRT1;
    logic                STRT2;
    logic                SBY;
    logic                MSTP;
    logic                MSTRTP;
    logic                WL15;
    logic                WL16;
    logic [NUM_TP-1:0]   T;
    logic [PHASES-1:0]   PHS;
    logic                MCT_END;
    logic                GOJAM;
    logic                STOPPED;
    logic [SCALER_W-1:0] FS;
    logic                OVF;
    logic                UNF;

    modport master (
        output CLOCK_EN, GOJ1, STRT1, STRT2, SBY, MSTP, MSTRTP, WL15, WL16,
        input  T, PHS, MCT_END, GOJAM, STOPPED, FS, OVF, UNF
    );

    modport slave (
        input  CLOCK_EN, GOJ1, STRT1, STRT2, SBY, MSTP, MSTRTP, WL15, WL16,
        output T, PHS, MCT_END, GOJAM, STOPPED, FS, OVF, UNF
    );
endinterface

// File: rtl/timepulse_gen.sv
// Memory-cycle timepulse generator. Steps a phase counter inside a timepulse
// counter; NUM_TP timepulses of PHASES phases make one memory cycle (MCT).
// A restart request forces a GOJAM pass (last timepulse, phase 0) that runs
// out without counting as an MCT. Monitor stop halts at the end of an MCT,
// monitor start releases one MCT. OVF/UNF sample the write-line sign bits on
// entry to phase OVF_PHASE.
// Ports:
//   SIM_CLK  clock, rising edge
//   SIM_RST  synchronous active-high reset
//   bus      timepulse_gen_if.slave (requests in, timing/status out)
module timepulse_gen #(
    parameter int unsigned NUM_TP    = 12,
    parameter int unsigned PHASES    = 4,
    parameter int unsigned SCALER_W  = 8,
    parameter int unsigned OVF_PHASE = 2
) (
    input  logic           SIM_CLK,
    input  logic           SIM_RST,
    timepulse_gen_if.slave bus
);
    localparam int unsigned TP_W = (NUM_TP > 1) ? $clog2(NUM_TP) : 1;
    localparam int unsigned PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    localparam logic [TP_W-1:0]   TP_LAST = TP_W'(NUM_TP - 1);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]   PH_OVF  = PH_W'(OVF_PHASE);
    localparam logic [NUM_TP-1:0] T_RST   = NUM_TP'(1) << (NUM_TP - 1);
    localparam logic [PHASES-1:0] PHS_RST = PHASES'(1);

    // GOJAM: restart pass running out; RUN: normal MCTs; STOP: monitor halt
    typedef enum logic [1:0] {
        ST_GOJAM = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TP_W-1:0]     tp_q, tp_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [NUM_TP-1:0]   t_q, t_d;
    logic [PHASES-1:0]   phs_q, phs_d;
    logic                gojam_q, gojam_d;
    logic                stopped_q, stopped_d;
    logic                mct_end_q, mct_end_d;
    logic [SCALER_W-1:0] fs_q, fs_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                req;
    logic                step;
    logic                wrap;

    assign req = bus.GOJ1 | bus.STRT1 | bus.STRT2 | bus.SBY;

    // State and registered outputs
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q   <= ST_GOJAM;
            tp_q      <= TP_LAST;
            ph_q      <= '0;
            t_q       <= T_RST;
            phs_q     <= PHS_RST;
            gojam_q   <= 1'b1;
            stopped_q <= 1'b0;
            mct_end_q <= 1'b0;
            fs_q      <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tp_q      <= tp_d;
            ph_q      <= ph_d;
            t_q       <= t_d;
            phs_q     <= phs_d;
            gojam_q   <= gojam_d;
            stopped_q <= stopped_d;
            mct_end_q <= mct_end_d;
            fs_q      <= fs_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        tp_d      = tp_q;
        ph_d      = ph_q;
        fs_d      = fs_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mct_end_d = 1'b0;
        step      = 1'b0;
        wrap      = 1'b0;

        if (req) begin
            // Restart wins over everything, including a pending stop
            state_d = ST_GOJAM;
            tp_d    = TP_LAST;
            ph_d    = '0;
        end else if (state_q == ST_STOP) begin
            // Leaving the halt costs one cycle; the next enable takes the step
            if (!bus.MSTP || bus.MSTRTP) begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_GOJAM || state_q == ST_RUN) begin
            step = bus.CLOCK_EN;
        end else begin
            state_d = ST_GOJAM;
            tp_d    = TP_LAST;
            ph_d    = '0;
        end

        if (step) begin
            wrap = (tp_q == TP_LAST) && (ph_q == PH_LAST);
            if (ph_q == PH_LAST) begin
                ph_d = '0;
                tp_d = (tp_q == TP_LAST) ? '0 : tp_q + TP_W'(1);
            end else begin
                ph_d = ph_q + PH_W'(1);
            end

            if (ph_d == PH_OVF) begin
                ovf_d = bus.WL15 & ~bus.WL16;
                unf_d = ~bus.WL15 & bus.WL16;
            end

            // A GOJAM pass ends silently; a real MCT pulses and counts
            if (wrap) begin
                if (state_q == ST_GOJAM) begin
                    state_d = ST_RUN;
                end else begin
                    mct_end_d = 1'b1;
                    fs_d      = fs_q + SCALER_W'(1);
                    if (bus.MSTP) begin
                        state_d = ST_STOP;
                    end
                end
            end
        end

        t_d       = NUM_TP'(1) << tp_d;
        phs_d     = PHASES'(1) << ph_d;
        gojam_d   = (state_d == ST_GOJAM);
        stopped_d = (state_d == ST_STOP);
    end

    assign bus.T       = t_q;
    assign bus.PHS     = phs_q;
    assign bus.MCT_END = mct_end_q;
    assign bus.GOJAM   = gojam_q;
    assign bus.STOPPED = stopped_q;
    assign bus.FS      = fs_q;
    assign bus.OVF     = ovf_q;
    assign bus.UNF     = unf_q;

endmodule

// File: doc/timepulse_gen.md
TIMEPULSE_GEN -- requirements
Module: timepulse_gen

Interface
REQ-001 SHALL provide parameter NUM_TP, default 12, number of timepulses per memory cycle (MCT); legal range 2..32.
REQ-002 SHALL provide parameter PHASES, default 4, clock phases per timepulse; legal range 2..8.
REQ-003 SHALL provide parameter SCALER_W, default 8, width of the MCT scaler.
REQ-004 SHALL provide parameter OVF_PHASE, default 2, the phase index that strobes overflow sampling; legal range 0..PHASES-1.
REQ-005 SHALL have port SIM_CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port SIM_RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port CLOCK_EN, input, 1 bit: phase-advance enable; one step per high cycle.
REQ-008 SHALL have ports GOJ1, STRT1, STRT2 and SBY, each input, 1 bit: restart requests, level-sensitive.
REQ-009 SHALL have port MSTP, input, 1 bit: monitor stop, halting at the end of an MCT.
REQ-010 SHALL have port MSTRTP, input, 1 bit: monitor start, which releases one MCT while stopped.
REQ-011 SHALL have ports WL15 and WL16, inputs, 1 bit each: write-line sign bits.
REQ-012 SHALL have port T, output, NUM_TP bits: one-hot timepulse, where bit k means T(k+1).
REQ-013 SHALL have port PHS, output, PHASES bits: one-hot current phase.
REQ-014 SHALL have ports MCT_END, GOJAM and STOPPED, each output, 1 bit.
REQ-015 SHALL have port FS, output, SCALER_W bits: MCT scaler.
REQ-016 SHALL have ports OVF and UNF, each output, 1 bit: overflow and underflow flags.

Function
REQ-017 SHALL hold state tp (0..NUM_TP-1) and ph (0..PHASES-1), with T = onehot(tp) and PHS = onehot(ph); exactly one bit of each SHALL be high at all times.
REQ-018 SHALL define REQ = GOJ1|STRT1|STRT2|SBY, and a "step" as a cycle with CLOCK_EN=1, REQ=0 and STOPPED=0.
REQ-019 On a step, ph SHALL increment; when ph=PHASES-1 it SHALL wrap to 0 and tp SHALL increment, wrapping from NUM_TP-1 to 0.
REQ-020 In any cycle with REQ=1, the block SHALL set GOJAM=1, force tp=NUM_TP-1 and ph=0, and clear STOPPED, regardless of CLOCK_EN or MSTP; REQ SHALL have priority over all other events.
REQ-021 GOJAM SHALL clear on the step that wraps tp from NUM_TP-1 to 0; a GOJAM pass therefore lasts PHASES steps after REQ drops.
REQ-022 MCT_END SHALL be a 1-cycle pulse, registered in the cycle after a step that wraps tp to 0 with GOJAM=0 before that step; GOJAM passes SHALL NOT pulse MCT_END.
REQ-023 FS SHALL increment modulo 2^SCALER_W on each step that produces MCT_END.
REQ-024 If MSTP=1 on a step that produces MCT_END, STOPPED SHALL be set; tp and ph SHALL still wrap to 0,0, and stepping SHALL halt.
REQ-025 While STOPPED=1 and REQ=0, MSTP=0 or MSTRTP=1 SHALL clear STOPPED in that cycle, with no step taken; stepping SHALL resume on the next CLOCK_EN.
REQ-026 Single-step behaviour SHALL follow from REQ-024/025: a 1-cycle MSTRTP pulse while MSTP=1 runs exactly one MCT (NUM_TP*PHASES steps) and then stops again.
REQ-027 On each step entering ph=OVF_PHASE, the block SHALL load OVF = WL15&~WL16 and UNF = ~WL15&WL16; both flags SHALL hold until the next such load.
REQ-028 CLOCK_EN=0 SHALL freeze tp, ph, FS, OVF and UNF; STOPPED and GOJAM SHALL still respond to REQ, MSTP and MSTRTP.

Reset
REQ-029 SIM_RST=1 SHALL set tp=NUM_TP-1, ph=0, GOJAM=1, STOPPED=0, MCT_END=0, FS=0, OVF=0 and UNF=0.
REQ-030 After SIM_RST releases, the block SHALL behave as a GOJAM pass per REQ-021; reset mid-MCT SHALL discard the partial MCT without pulsing MCT_END.

Verification (defaults; CLOCK_EN=1 unless stated)
REQ-031 Reset release with REQ=0 SHALL give:
- T[11]=1 and GOJAM=1 for 4 cycles;
- then T[0] with PHS=0001 and GOJAM=0;
- first MCT_END 48 cycles later;
- FS=1.
REQ-032 GOJ1 high for 10 cycles during T05 phase 2 SHALL give:
- next cycle T[11] with PHS=0001 and GOJAM=1, held for 10 cycles;
- then 4 steps to T01;
- no MCT_END for the aborted MCT.
REQ-033 MSTP=1 during an MCT SHALL give:
- MCT_END at the end of that MCT;
- STOPPED=1 with T[0] and PHS=0001 frozen.
 A 1-cycle MSTRTP pulse SHALL then run exactly 48 steps, give one more MCT_END and FS+1, and set STOPPED=1 again.
REQ-034 With FS=255, one MCT SHALL give FS=0 with MCT_END=1.
REQ-035 OVF/UNF sampling SHALL give:
- WL15=1, WL16=0 at the OVF_PHASE step: OVF=1, UNF=0;
- WL15=0, WL16=1 at the next strobe: OVF=0, UNF=1;
- WL15=WL16: both flags 0.
 Changes on WL15/WL16 between strobes SHALL have no effect.
REQ-036 CLOCK_EN toggled 1/0 with NUM_TP=3 and PHASES=2 SHALL give MCT_END every 6 enabled steps (12 cycles), with T sequence 001→010→100→001.
